// File: rtl/mux_sweep_ctrl_if.sv
// Bundle between the sweep controller and its host/mux: start strobe, mux drive,
// sampled mux output and the captured results.
interface mux_sweep_ctrl_if;
  logic        start;
  logic        f;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail_valid;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail;

  modport master (
    output start, f,
    input  a, b, c, d, busy, done, pass, fail_valid,
    input  truth_table, mismatch_count, first_fail
  );

  modport slave (
    input  start, f,
    output a, b, c, d, busy, done, pass, fail_valid,
    output truth_table, mismatch_count, first_fail
  );
endinterface

// File: rtl/mux_sweep_ctrl.sv
// Sweeps the 16 {A,B,C,D} vectors through a 4:1 mux, captures F per vector and
// compares the captured truth table with EXPECTED.
module mux_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'h2435
) (
  input  logic             clk,
  input  logic             reset,
  mux_sweep_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic        fail_valid_q;
  logic [15:0] truth_table_q;
  logic [4:0]  mismatch_q;
  logic [3:0]  first_fail_q;

  logic        miss_d;
  logic [4:0]  mismatch_d;

  // pass in DONE must see the count including the final sample, so it is formed here
  always_comb begin
    miss_d     = bus.f ^ EXPECTED[idx_q];
    mismatch_d = mismatch_q + {4'd0, miss_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= 4'd0;
      cnt_q         <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_valid_q  <= 1'b0;
      truth_table_q <= 16'd0;
      mismatch_q    <= 5'd0;
      first_fail_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            idx_q         <= 4'd0;
            truth_table_q <= 16'd0;
            mismatch_q    <= 5'd0;
            first_fail_q  <= 4'd0;
            fail_valid_q  <= 1'b0;
            pass_q        <= 1'b0;
            cnt_q         <= CNT_LOAD;
            busy_q        <= 1'b1;
            state_q       <= SETTLE;
          end else begin
            state_q <= IDLE;
          end
        end
        SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        SAMPLE: begin
          truth_table_q[idx_q] <= bus.f;
          mismatch_q           <= mismatch_d;
          if (miss_d && !fail_valid_q) begin
            first_fail_q <= idx_q;
            fail_valid_q <= 1'b1;
          end
          if (idx_q == 4'd15) begin
            done_q  <= 1'b1;
            pass_q  <= (mismatch_d == 5'd0);
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 4'd1;
            cnt_q   <= CNT_LOAD;
            state_q <= SETTLE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a              = idx_q[3];
  assign bus.b              = idx_q[2];
  assign bus.c              = idx_q[1];
  assign bus.d              = idx_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail_valid     = fail_valid_q;
  assign bus.truth_table    = truth_table_q;
  assign bus.mismatch_count = mismatch_q;
  assign bus.first_fail     = first_fail_q;

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// Directed bench for mux_sweep_ctrl: a behavioural mux with selectable faults,
// a table of sweep scenarios and hand-written reset/abort sequences.
module tb_mux_sweep_ctrl;

  logic clk;
  logic reset;
  int   mode;
  int   n_tests;
  int   n_fail;

  logic [15:0] gold_s;
  logic [3:0]  abcd_s;

  mux_sweep_ctrl_if bus ();

  mux_sweep_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign gold_s = 16'h2435;
  assign abcd_s = {bus.a, bus.b, bus.c, bus.d};

  // mode 0 good mux, 1 stuck-at-0, 2 inverted, 3 flipped at index 10
  assign bus.f = (mode == 0) ? gold_s[abcd_s] :
                 (mode == 1) ? 1'b0 :
                 (mode == 2) ? ~gold_s[abcd_s] :
                               (gold_s[abcd_s] ^ (abcd_s == 4'd10));

  typedef struct {
    int          mode;
    int          poke;
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic [3:0]  ff;
    logic        fv;
    logic        pass;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input int poke, output int lat);
    bit poked;
    poked = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    chk("abcd_after_start", {28'd0, abcd_s}, 32'd0);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.start) bus.start = 1'b0;
      if (bus.done) break;
      if (poke >= 0 && !poked && abcd_s == 4'(poke)) begin
        bus.start = 1'b1;
        poked     = 1'b1;
      end
    end
    if (poke >= 0) chk("poke_applied", {31'd0, poked}, 32'd1);
    chk("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    n_tests   = 0;
    n_fail    = 0;
    mode      = 0;
    reset     = 1'b0;
    bus.start = 1'b0;

    vecs[0] = '{mode: 0, poke: -1, tt: 16'h2435, cnt: 5'd0,  ff: 4'd0,  fv: 1'b0, pass: 1'b1};
    vecs[1] = '{mode: 1, poke: -1, tt: 16'h0000, cnt: 5'd6,  ff: 4'd0,  fv: 1'b1, pass: 1'b0};
    vecs[2] = '{mode: 2, poke: -1, tt: 16'hDBCA, cnt: 5'd16, ff: 4'd0,  fv: 1'b1, pass: 1'b0};
    vecs[3] = '{mode: 3, poke: -1, tt: 16'h2035, cnt: 5'd1,  ff: 4'd10, fv: 1'b1, pass: 1'b0};
    vecs[4] = '{mode: 0, poke: 5,  tt: 16'h2435, cnt: 5'd0,  ff: 4'd0,  fv: 1'b0, pass: 1'b1};

    // Asynchronous reset asserted between clock edges
    #7;
    reset = 1'b1;
    #1;
    chk("rst_abcd",  {28'd0, abcd_s}, 32'd0);
    chk("rst_flags", {28'd0, bus.busy, bus.done, bus.pass, bus.fail_valid}, 32'd0);
    chk("rst_tt",    {16'd0, bus.truth_table}, 32'd0);
    chk("rst_cnt",   {27'd0, bus.mismatch_count}, 32'd0);
    chk("rst_ff",    {28'd0, bus.first_fail}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      run_sweep(vecs[i].poke, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd48);
      chk($sformatf("v%0d_busy_in_done", i), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("v%0d_tt", i), {16'd0, bus.truth_table}, {16'd0, vecs[i].tt});
      chk($sformatf("v%0d_cnt", i), {27'd0, bus.mismatch_count}, {27'd0, vecs[i].cnt});
      chk($sformatf("v%0d_ff", i), {28'd0, bus.first_fail}, {28'd0, vecs[i].ff});
      chk($sformatf("v%0d_fv", i), {31'd0, bus.fail_valid}, {31'd0, vecs[i].fv});
      chk($sformatf("v%0d_pass", i), {31'd0, bus.pass}, {31'd0, vecs[i].pass});
      chk($sformatf("v%0d_abcd_last", i), {28'd0, abcd_s}, 32'd15);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
      chk($sformatf("v%0d_busy_fall", i), {31'd0, bus.busy}, 32'd0);
      chk($sformatf("v%0d_tt_hold", i), {16'd0, bus.truth_table}, {16'd0, vecs[i].tt});
      chk($sformatf("v%0d_pass_hold", i), {31'd0, bus.pass}, {31'd0, vecs[i].pass});
    end

    // Abort a sweep with reset at idx 7, then re-sweep from 0
    mode = 2;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (abcd_s != 4'd7 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idx7_reached", {28'd0, abcd_s}, 32'd7);
    chk("partial_tt_nonzero", {31'd0, (bus.truth_table != 16'd0)}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_abcd", {28'd0, abcd_s}, 32'd0);
    chk("abort_tt",   {16'd0, bus.truth_table}, 32'd0);
    chk("abort_cnt",  {27'd0, bus.mismatch_count}, 32'd0);
    chk("abort_fv",   {31'd0, bus.fail_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mode  = 0;
    run_sweep(-1, lat);
    chk("resweep_latency", lat, 32'd48);
    chk("resweep_tt",   {16'd0, bus.truth_table}, 32'h2435);
    chk("resweep_pass", {31'd0, bus.pass}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mux_sweep_ctrl.md
# mux_sweep_ctrl

Sequencing controller that sweeps all 16 input combinations {A,B,C,D} through an attached 4-input, 1-output mux datapath, waits a programmable settle time per vector, and captures the output F into a 16-entry truth table. It compares the captured table against an expected table and reports pass/fail, the mismatch count and the first failing index. It sits between a host or bench `start` strobe and the mux's A/B/C/D inputs and F output, and is the bring-up and self-check sequencer for the mux variants.

## Interface
- `SETTLE_CYCLES`, default 2: clock cycles held per vector before sampling F; legal range 1..15.
- `EXPECTED`, default 16'h2435: golden truth table; bit i is the expected F for index i = {A,B,C,D}, with A as the MSB.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: sweep request; sampled only in IDLE.
- `f` input 1: F output of the mux under sequence.
- `a`, `b`, `c`, `d` output 1 each: registered mux drive; {a,b,c,d} = current index.
- `busy` output 1: high from the start edge until DONE is exited.
- `done` output 1: one-cycle pulse when results are valid.
- `pass` output 1: 1 when the captured table equals EXPECTED; valid from `done` until the next start.
- `truth_table` output 16: captured F values; bit i belongs to index i.
- `mismatch_count` output 5: number of bits differing from EXPECTED, range 0..16.
- `first_fail` output 4: lowest mismatching index; 0 when none.
- `fail_valid` output 1: at least one mismatch has been seen.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE**
  - On `start`=1: clear idx, truth_table, mismatch_count, first_fail, fail_valid and pass.
  - Load the settle counter with SETTLE_CYCLES-1, set busy, and go to SETTLE.
  - On `start`=0: stay in IDLE.
- **SETTLE**
  - Hold {a,b,c,d} = idx.
  - Decrement the counter; at 0 go to SAMPLE.
- **SAMPLE** (one cycle)
  - Write truth_table[idx] <= f.
  - If f != EXPECTED[idx], increment mismatch_count. If fail_valid is 0, also set first_fail <= idx and fail_valid <= 1.
  - If idx==15, go to DONE. Otherwise idx <= idx+1, reload the counter, and go to SETTLE.
- **DONE** (one cycle)
  - done=1 and pass = (mismatch_count==0), using the count updated by the final SAMPLE.
  - busy deasserts on exit, and the state returns to IDLE.
- idx is 4 bits. Wrap past 15 never occurs; the exit is decided on idx==15.
- mismatch_count is 5 bits and saturates naturally at 16.
- `start` is ignored outside IDLE, including during DONE.
- Results (truth_table, mismatch_count, first_fail, fail_valid, pass) hold until the next accepted start.
- Reset mid-sweep aborts immediately. No partial results are retained.
- Reset values:
  - state IDLE
  - a, b, c, d = 0
  - busy, done, pass, fail_valid = 0
  - truth_table = 0, mismatch_count = 0, first_fail = 0

## Timing
- Edge E0 is the edge at which `start` is accepted.
- Vector k is driven from edge E0+k·(S+1), where S = SETTLE_CYCLES.
- f for vector k is sampled at edge E0+(k+1)·(S+1), which gives S+1 cycles of settle; this must exceed the mux propagation delay.
- `done` is high for exactly the one cycle following edge E0+16·(S+1). For S=2 this is 48 cycles after E0.
- busy falls at edge E0+16·(S+1)+1.
- A new start is accepted no earlier than that edge, in IDLE.
- {a,b,c,d} keeps the last index (15) after the sweep and returns to 0 only on reset or a new start.
- No combinational path from `f` to any output. All outputs are registered.

## Test plan
- **Reset values:** assert `reset` asynchronously mid-cycle -> all outputs read zero immediately, with no clock edge required.
- **Correct mux:** connect a correct mux model, S=2, pulse `start` -> truth_table=16'h2435, mismatch_count=0, pass=1, fail_valid=0, done pulse 48 cycles after the start edge.
- **f stuck at 0:** -> truth_table=16'h0000, mismatch_count=6, first_fail=0, fail_valid=1, pass=0.
- **f inverted:** -> truth_table=16'hDBCA, mismatch_count=16, first_fail=0, pass=0.
- **Single-bit fault:** f flipped only at index 10 ({A,B,C,D}=1010) -> mismatch_count=1, first_fail=10, truth_table=16'h2035, pass=0.
- **Start while busy, then reset mid-sweep:** pulse `start` at idx=5 -> ignored, and the sweep completes normally at the scheduled cycle. Then assert `reset` at idx=7 of a new sweep -> busy=0, abcd=0, truth_table=0. The next start re-sweeps from idx 0.
